// File: rtl/hazard_pkg.sv
// Shared definitions for the RAW hazard scoreboard: default latencies,
// counter-width helper and the last-issue record used for execute-stage squash.
package hazard_pkg;

   localparam int DEF_NOFWD_LAT = 2;
   localparam int DEF_LOAD_LAT  = 1;

   // Record fields are sized for the largest supported configuration.
   localparam int REC_SEL_W = 8;
   localparam int REC_CNT_W = 8;

   function automatic int calc_cnt_w(input int nofwd_lat, input int load_lat);
      int max_lat;
      max_lat = (nofwd_lat > load_lat) ? nofwd_lat : load_lat;
      return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
   endfunction

   typedef struct packed {
      logic                 v;
      logic [REC_SEL_W-1:0] dst;
      logic [REC_CNT_W-1:0] prev;
   } issue_rec_t;

endpackage

// File: rtl/hazard_reg_counter.sv
// Per-register pending-write countdown: reset, freeze, load on issue,
// restore on squash, otherwise count down to zero.
module hazard_reg_counter import hazard_pkg::*; #(
   parameter int CNT_W = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_hold,
   input  logic             i_load_en,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_restore_en,
   input  logic [CNT_W-1:0] i_restore_val,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   // A new issue outranks a squash restore; both outrank the decrement.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= {CNT_W{1'b0}};
      end else if (i_hold) begin
         r_cnt <= r_cnt;
      end else if (i_load_en) begin
         r_cnt <= i_load_val;
      end else if (i_restore_en) begin
         r_cnt <= i_restore_val;
      end else if (r_cnt != {CNT_W{1'b0}}) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard unit with per-register pending-write counters.
// Optional feature macro: HAZARD_SCOREBOARD_FORWARD_EN (EX/MEM, MEM/WB forwarding present).
module hazard_scoreboard import hazard_pkg::*; #(
   parameter int NUM_REGS  = 8,
   parameter int REG_SEL_W = 3,
   parameter int NOFWD_LAT = DEF_NOFWD_LAT,
   parameter int LOAD_LAT  = DEF_LOAD_LAT
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_hold,
   input  logic                 i_id_valid,
   input  logic [REG_SEL_W-1:0] i_rs,
   input  logic [REG_SEL_W-1:0] i_rt,
   input  logic                 i_rs_used,
   input  logic                 i_rt_used,
   input  logic                 i_reg_write,
   input  logic [REG_SEL_W-1:0] i_dst,
   input  logic                 i_is_load,
   input  logic                 i_flush_id,
   input  logic                 i_flush_ex,
   output logic                 o_stall,
   output logic                 o_issue,
   output logic [NUM_REGS-1:0]  o_busy,
   output logic [15:0]          o_stall_count
);

   localparam int CNT_W    = calc_cnt_w(NOFWD_LAT, LOAD_LAT);
   localparam int SEL_SPAN = 2 ** REG_SEL_W;

   logic [CNT_W-1:0] w_cnt_pad [SEL_SPAN];
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_restore_val;
   logic             w_rs_busy;
   logic             w_rt_busy;
   logic             w_stall;
   logic             w_issue;
   logic             w_wr_issue;
   logic             w_restore_en;
   issue_rec_t       r_rec;
   logic [15:0]      r_stall_count;

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
   assign w_load_val = i_is_load ? CNT_W'(LOAD_LAT) : {CNT_W{1'b0}};
`else
   logic w_unused_is_load;
   assign w_unused_is_load = i_is_load;
   assign w_load_val       = CNT_W'(NOFWD_LAT);
`endif

   // Select slots beyond NUM_REGS read as never pending.
   assign w_rs_busy  = i_rs_used & (w_cnt_pad[i_rs] != {CNT_W{1'b0}});
   assign w_rt_busy  = i_rt_used & (w_cnt_pad[i_rt] != {CNT_W{1'b0}});
   assign w_stall    = ~i_rst & i_id_valid & ~i_flush_id & (w_rs_busy | w_rt_busy);
   assign w_issue    = ~i_rst & ~i_hold & i_id_valid & ~i_flush_id & ~w_stall;
   assign w_wr_issue = w_issue & i_reg_write;

   assign w_restore_en  = ~i_hold & i_flush_ex & r_rec.v;
   assign w_restore_val = CNT_W'((r_rec.prev != {REC_CNT_W{1'b0}}) ?
                                 (r_rec.prev - REC_CNT_W'(1)) : {REC_CNT_W{1'b0}});

   for (genvar r = 0; r < SEL_SPAN; r++) begin : g_reg
      if (r < NUM_REGS) begin : g_real
         hazard_reg_counter #(
            .CNT_W (CNT_W)
         ) u_cnt (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_hold        (i_hold),
            .i_load_en     (w_wr_issue & (i_dst == REG_SEL_W'(r))),
            .i_load_val    (w_load_val),
            .i_restore_en  (w_restore_en & (r_rec.dst == REC_SEL_W'(r))),
            .i_restore_val (w_restore_val),
            .o_cnt         (w_cnt_pad[r])
         );
         assign o_busy[r] = ~i_rst & (w_cnt_pad[r] != {CNT_W{1'b0}});
      end else begin : g_none
         assign w_cnt_pad[r] = {CNT_W{1'b0}};
      end
   end

   // Remember the youngest writer so a squash in execute can hand back its reservation.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rec <= '0;
      end else if (i_hold) begin
         r_rec <= r_rec;
      end else if (w_wr_issue) begin
         r_rec <= {1'b1, REC_SEL_W'(i_dst), REC_CNT_W'(w_cnt_pad[i_dst])};
      end else begin
         r_rec <= '0;
      end
   end

   // Saturating count of stall cycles that actually cost a pipeline slot.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stall_count <= 16'h0000;
      end else if (w_stall & ~i_hold & (r_stall_count != 16'hFFFF)) begin
         r_stall_count <= r_stall_count + 16'h0001;
      end else begin
         r_stall_count <= r_stall_count;
      end
   end

   assign o_stall       = w_stall;
   assign o_issue       = w_issue;
   assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: drivers queue the expected issue cycle of each instruction,
// a negedge monitor pops and compares whenever the DUT reports an issue.
module tb_hazard_scoreboard;

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
   localparam int ALU_L = 0;
   localparam int LD_L  = 1;
`else
   localparam int ALU_L = 2;
   localparam int LD_L  = 2;
`endif

   typedef struct {
      int         cyc;
      logic [2:0] tag;
   } exp_t;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_hold = 1'b0;
   logic       i_id_valid = 1'b0;
   logic [2:0] i_rs = 3'd0;
   logic [2:0] i_rt = 3'd0;
   logic       i_rs_used = 1'b0;
   logic       i_rt_used = 1'b0;
   logic       i_reg_write = 1'b0;
   logic [2:0] i_dst = 3'd0;
   logic       i_is_load = 1'b0;
   logic       i_flush_id = 1'b0;
   logic       i_flush_ex = 1'b0;
   logic       o_stall;
   logic       o_issue;
   logic [7:0] o_busy;
   logic [15:0] o_stall_count;

   logic        s2_stall;
   logic        s2_issue;
   logic [7:0]  s2_busy;
   logic [15:0] s2_stall_count;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic [15:0] sc0;

   hazard_scoreboard #(.NUM_REGS(8), .REG_SEL_W(3), .NOFWD_LAT(2), .LOAD_LAT(1)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_hold(i_hold), .i_id_valid(i_id_valid),
      .i_rs(i_rs), .i_rt(i_rt), .i_rs_used(i_rs_used), .i_rt_used(i_rt_used),
      .i_reg_write(i_reg_write), .i_dst(i_dst), .i_is_load(i_is_load),
      .i_flush_id(i_flush_id), .i_flush_ex(i_flush_ex),
      .o_stall(o_stall), .o_issue(o_issue), .o_busy(o_busy), .o_stall_count(o_stall_count)
   );

   // Long-latency instance: a self-dependent load stalls nearly every cycle.
   hazard_scoreboard #(.NUM_REGS(8), .REG_SEL_W(3), .NOFWD_LAT(200), .LOAD_LAT(200)) dut_sat (
      .i_clk(i_clk), .i_rst(i_rst), .i_hold(1'b0), .i_id_valid(1'b1),
      .i_rs(3'd0), .i_rt(3'd0), .i_rs_used(1'b1), .i_rt_used(1'b0),
      .i_reg_write(1'b1), .i_dst(3'd0), .i_is_load(1'b1),
      .i_flush_id(1'b0), .i_flush_ex(1'b0),
      .o_stall(s2_stall), .o_issue(s2_issue), .o_busy(s2_busy), .o_stall_count(s2_stall_count)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_issue) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue: issue at cycle %0d dst %0d, none expected", cyc, i_dst);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (cyc != e.cyc || i_dst != e.tag) begin
               errors++;
               $display("FAIL issue_timing: got cycle %0d tag %0d, expected cycle %0d tag %0d",
                        cyc, i_dst, e.cyc, e.tag);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic idle();
      i_id_valid  = 1'b0;
      i_rs_used   = 1'b0;
      i_rt_used   = 1'b0;
      i_reg_write = 1'b0;
      i_is_load   = 1'b0;
      i_flush_id  = 1'b0;
      i_flush_ex  = 1'b0;
   endtask

   task automatic drive(input logic [2:0] rs, input logic rsu, input logic [2:0] rt, input logic rtu,
                        input logic wr, input logic [2:0] dst, input logic ld);
      i_id_valid  = 1'b1;
      i_rs        = rs;
      i_rs_used   = rsu;
      i_rt        = rt;
      i_rt_used   = rtu;
      i_reg_write = wr;
      i_dst       = dst;
      i_is_load   = ld;
      i_flush_id  = 1'b0;
      i_flush_ex  = 1'b0;
   endtask

   task automatic expect_issue(input int wait_cycles, input logic [2:0] tag);
      exp_t e;
      e.cyc = cyc + wait_cycles;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic wait_issue(input string name);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge i_clk);
         if (o_issue) begin
            got = 1'b1;
         end else begin
            @(posedge i_clk); #1;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no issue within 40 cycles", name);
         if (exp_q.size() > 0) void'(exp_q.pop_back());
      end
      @(posedge i_clk); #1;
      idle();
   endtask

   task automatic send(input logic [2:0] rs, input logic rsu, input logic [2:0] rt, input logic rtu,
                       input logic wr, input logic [2:0] dst, input logic ld, input int wait_cycles,
                       input string name);
      expect_issue(wait_cycles, dst);
      drive(rs, rsu, rt, rtu, wr, dst, ld);
      wait_issue(name);
   endtask

   initial begin
      // Reset: outputs quiet during and right after.
      drive(3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk("rst_stall", o_stall, 0);
      chk("rst_issue", o_issue, 0);
      @(posedge i_clk); #1;
      idle();
      i_rst = 1'b0;
      chk("post_rst_busy", o_busy, 0);
      chk("post_rst_stall_count", o_stall_count, 0);
      @(posedge i_clk); #1;

      // ALU write r3, dependent read of r3.
      sc0 = o_stall_count;
      send(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 0, "alu_wr");
      chk("alu_busy3", o_busy[3], (ALU_L != 0) ? 1 : 0);
      expect_issue(ALU_L, 3'd7);
      drive(3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0);
      #1;
      chk("alu_stall", o_stall, (ALU_L != 0) ? 1 : 0);
      wait_issue("alu_rd");
      chk("alu_stall_count", o_stall_count - sc0, ALU_L);

      // Load r3, dependent read.
      sc0 = o_stall_count;
      send(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 0, "ld_wr");
      send(3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 3'd6, 1'b0, LD_L, "ld_rd");
      chk("ld_stall_count", o_stall_count - sc0, LD_L);

      // Write r2, squash it in execute; dependent then issues freely.
      send(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 0, "fl_wr");
      chk("fl_busy2_before", o_busy[2], 1);
      drive(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1);
      i_flush_id = 1'b1;
      i_flush_ex = 1'b1;
      @(posedge i_clk); #1;
      idle();
      chk("fl_busy2_after", o_busy[2], 0);
      chk("fl_busy4", o_busy[4], 0);
      send(3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd5, 1'b0, 0, "fl_rd");

      // Write r5, then freeze for 4 cycles with a dependent waiting.
      send(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1, 0, "hold_wr");
      sc0 = o_stall_count;
      i_hold = 1'b1;
      expect_issue(4 + LD_L, 3'd7);
      drive(3'd5, 1'b1, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("hold_busy5", o_busy[5], 1);
         chk("hold_stall", o_stall, 1);
         @(posedge i_clk); #1;
      end
      i_hold = 1'b0;
      wait_issue("hold_rd");
      chk("hold_stall_count", o_stall_count - sc0, LD_L);

      // Back-to-back writes to r1: youngest writer sets the wait.
      send(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 0, "waw_wr1");
      send(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 0, "waw_wr2");
      send(3'd1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0, LD_L, "waw_rd");

      // Read-modify-write of r6 waits only on the older count; then read via rt.
      send(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 1'b1, 0, "rmw_wr");
      send(3'd6, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 1'b1, LD_L, "rmw");
      send(3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 3'd7, 1'b0, LD_L, "rmw_rd_rt");

      // Reset in the middle of a stall.
      send(3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1, 0, "mrst_wr");
      drive(3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0);
      #1;
      chk("mrst_stall_pre", o_stall, 1);
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      #1;
      chk("mrst_stall_in", o_stall, 0);
      chk("mrst_busy_in", o_busy, 0);
      @(posedge i_clk); #1;
      i_rst  = 1'b0;
      i_hold = 1'b1;
      #1;
      chk("mrst_stall_after", o_stall, 0);
      chk("mrst_busy_after", o_busy, 0);
      chk("mrst_stall_count", o_stall_count, 0);
      @(posedge i_clk); #1;
      i_hold = 1'b0;
      expect_issue(0, 3'd7);
      wait_issue("mrst_rd");

      // Saturation on the long-latency instance.
      while (cyc < 70100) @(posedge i_clk);
      #1;
      chk("sat_stall_count", s2_stall_count, 16'hFFFF);
      chk("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
